tlk2711_axi_mem_slave: RTL and testbench

AXI4 memory-mapped responder backed by an internal word-addressed RAM. It answers the read and write bursts issued by the TLK2711 DMA datamover master, so TX/RX DMA paths can be looped back and verified without the PS HP port. Read and write channels are independent and each handles one outstanding burst. Burst counters are exposed for debug.

---
 rtl/tlk2711_axi_mem_slave.sv | 272 +++++++++++++++++++++++++++
 tb/tb_tlk2711_axi_mem_slave.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_axi_mem_slave.sv
// AXI4 memory-mapped responder backed by an internal word-addressed RAM. Answers the
// INCR bursts issued by the TLK2711 DMA datamover so TX/RX DMA paths can be looped back
// without the PS HP port. Read and write channels are independent; each accepts one
// outstanding burst at a time.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axi_aw*                write-address channel (registered awready)
//   s_axi_w*                 write-data channel (wready high while a burst is open)
//   s_axi_b*                 write-response channel (SLVERR on illegal request / wlast error)
//   s_axi_ar*                read-address channel (registered arready)
//   s_axi_r*                 read-data channel (registered rdata, streams back-to-back)
//   o_wr_burst_cnt           completed write bursts (B handshakes), wraps
//   o_rd_burst_cnt           completed read bursts (rlast handshakes), wraps
module tlk2711_axi_mem_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_DEPTH  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    // write address
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    // write data
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    // read address
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    // read data
    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    // debug counters
    output logic [15:0]               o_wr_burst_cnt,
    output logic [15:0]               o_rd_burst_cnt
);

    localparam int unsigned NumBytes   = DATA_WIDTH / 8;
    localparam int unsigned OffsW      = $clog2(NumBytes);
    localparam int unsigned IdxW       = $clog2(MEM_DEPTH);
    localparam logic [2:0]  LegalSize  = 3'(OffsW);
    localparam logic [1:0]  BurstIncr  = 2'b01;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic       {RIdle, RData}        r_state_e;

    // Storage; deliberately not reset so contents survive rst.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Only the word-index field of the address is decoded; the rest is don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_e              w_state_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [IdxW-1:0]       w_idx_q;
    logic [7:0]            w_len_q;
    logic [7:0]            w_beat_q;
    logic                  w_legal_q;
    logic                  w_err_q;
    logic [15:0]           wr_cnt_q;

    logic                  aw_legal;
    logic                  w_beat_fire;
    logic                  w_final;
    logic                  w_err_d;

    assign aw_legal    = (s_axi_awburst == BurstIncr) && (s_axi_awsize == LegalSize);
    // wready_q is high exactly while in WData, so a valid beat there is a handshake.
    assign w_beat_fire = (w_state_q == WData) && s_axi_wvalid;
    assign w_final     = (w_beat_q == w_len_q);
    // wlast must be high on the final beat and low on every other beat.
    assign w_err_d     = w_err_q | (s_axi_wlast != w_final);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            bid_q     <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_legal_q <= 1'b0;
            w_err_q   <= 1'b0;
            wr_cnt_q  <= '0;
        end else begin
            unique case (w_state_q)
                WIdle: begin
                    awready_q <= 1'b1;
                    if (s_axi_awvalid && awready_q) begin
                        bid_q     <= s_axi_awid;
                        w_idx_q   <= s_axi_awaddr[OffsW +: IdxW];
                        w_len_q   <= s_axi_awlen;
                        w_beat_q  <= '0;
                        w_legal_q <= aw_legal;
                        w_err_q   <= !aw_legal;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= WData;
                    end
                end
                WData: begin
                    if (s_axi_wvalid) begin
                        w_err_q <= w_err_d;
                        // The beat count alone closes the burst; wlast only flags errors.
                        if (w_final) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= w_err_d ? RespSlvErr : RespOkay;
                            w_state_q <= WResp;
                        end else begin
                            w_beat_q <= w_beat_q + 8'd1;
                            w_idx_q  <= w_idx_q + IdxW'(1);
                        end
                    end
                end
                WResp: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        wr_cnt_q  <= wr_cnt_q + 16'd1;
                        awready_q <= 1'b1;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    // Byte-lane writes; illegal requests consume their beats without touching the RAM.
    always_ff @(posedge clk) begin
        if (!rst && w_beat_fire && w_legal_q) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_e              r_state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [1:0]            rresp_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IdxW-1:0]       r_idx_q;   // word index of the next beat to load
    logic [7:0]            r_len_q;
    logic [7:0]            r_beat_q;  // beat number currently presented
    logic                  r_legal_q;
    logic [15:0]           rd_cnt_q;

    logic                  ar_legal;
    logic [IdxW-1:0]       ar_idx;

    assign ar_legal = (s_axi_arburst == BurstIncr) && (s_axi_arsize == LegalSize);
    assign ar_idx   = s_axi_araddr[OffsW +: IdxW];

    // RAM reads here sample the pre-edge contents, so a same-cycle write to the same
    // word is seen by the read as the old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RespOkay;
            rid_q     <= '0;
            rdata_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_legal_q <= 1'b0;
            rd_cnt_q  <= '0;
        end else begin
            unique case (r_state_q)
                RIdle: begin
                    arready_q <= 1'b1;
                    if (s_axi_arvalid && arready_q) begin
                        rid_q     <= s_axi_arid;
                        rdata_q   <= ar_legal ? mem[ar_idx] : '0;
                        rresp_q   <= ar_legal ? RespOkay : RespSlvErr;
                        rlast_q   <= (s_axi_arlen == 8'd0);
                        rvalid_q  <= 1'b1;
                        r_idx_q   <= ar_idx + IdxW'(1);
                        r_len_q   <= s_axi_arlen;
                        r_beat_q  <= '0;
                        r_legal_q <= ar_legal;
                        arready_q <= 1'b0;
                        r_state_q <= RData;
                    end
                end
                RData: begin
                    // Without rready every R output simply holds.
                    if (s_axi_rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rd_cnt_q  <= rd_cnt_q + 16'd1;
                            arready_q <= 1'b1;
                            r_state_q <= RIdle;
                        end else begin
                            rdata_q  <= r_legal_q ? mem[r_idx_q] : '0;
                            r_idx_q  <= r_idx_q + IdxW'(1);
                            r_beat_q <= r_beat_q + 8'd1;
                            rlast_q  <= ((r_beat_q + 8'd1) == r_len_q);
                        end
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_awready  = awready_q;
    assign s_axi_wready   = wready_q;
    assign s_axi_bvalid   = bvalid_q;
    assign s_axi_bresp    = bresp_q;
    assign s_axi_bid      = bid_q;
    assign s_axi_arready  = arready_q;
    assign s_axi_rvalid   = rvalid_q;
    assign s_axi_rlast    = rlast_q;
    assign s_axi_rresp    = rresp_q;
    assign s_axi_rid      = rid_q;
    assign s_axi_rdata    = rdata_q;
    assign o_wr_burst_cnt = wr_cnt_q;
    assign o_rd_burst_cnt = rd_cnt_q;

endmodule

// File: tb/tb_tlk2711_axi_mem_slave.sv
// Self-checking bench for tlk2711_axi_mem_slave. A reference word memory tracks every
// legal write; expected R beats and B responses are queued when stimulus is issued and
// popped when the DUT hands them over.
module tb_tlk2711_axi_mem_slave;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [63:0] wdata, rdata;
    logic [15:0] wr_cnt, rd_cnt;

    always #5 clk = ~clk;

    tlk2711_axi_mem_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(64),
        .ID_WIDTH  (4),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awid    (awid),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awsize  (awsize),
        .s_axi_awburst (awburst),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bid     (bid),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_arid    (arid),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arsize  (arsize),
        .s_axi_arburst (arburst),
        .s_axi_rid     (rid),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .o_wr_burst_cnt(wr_cnt),
        .o_rd_burst_cnt(rd_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned exp_wr_cnt  = 0;
    int unsigned exp_rd_cnt  = 0;
    logic [63:0] model [DEPTH];
    r_exp_t      rq[$];
    b_exp_t      bq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_r(input logic [63:0] data, input logic [1:0] resp,
                          input logic last, input logic [3:0] id);
        r_exp_t e;
        e.data = data;
        e.resp = resp;
        e.last = last;
        e.id   = id;
        rq.push_back(e);
    endtask

    // Queue the beats a read should return, taken from the reference memory.
    task automatic push_model_read(input logic [31:0] addr, input int len,
                                   input bit legal, input logic [3:0] id);
        int idx;
        idx = int'(addr[14:3]);
        for (int i = 0; i <= len; i++) begin
            push_r(legal ? model[(idx + i) % DEPTH] : 64'h0, legal ? 2'b00 : 2'b10,
                   i == len, id);
        end
    endtask

    // wlast_mode 0: wlast on the final beat; 1: wlast never asserted.
    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id,
                            input logic [63:0] base, input logic [7:0] strb,
                            input int wlast_mode, input logic [1:0] exp_resp);
        b_exp_t be;
        b_exp_t got;
        int     n;
        int     idx;
        bit     legal;
        logic [63:0] d;
        legal   = (burst == 2'b01) && (size == 3'd3);
        be.id   = id;
        be.resp = exp_resp;
        bq.push_back(be);
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len); awsize = size;
        awburst = burst; awid = id;
        n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        vectors++;
        if (!awready) begin
            $display("FAIL aw_timeout: awready=%0b required 1", awready);
            miscompares++; awvalid = 1'b0; void'(bq.pop_back()); return;
        end
        tick();
        awvalid = 1'b0;
        idx = int'(addr[14:3]);
        for (int i = 0; i <= len; i++) begin
            d      = base + 64'(i);
            wvalid = 1'b1; wdata = d; wstrb = strb;
            wlast  = (wlast_mode == 0) ? (i == len) : 1'b0;
            n = 0;
            while (!wready && n < 20) begin tick(); n++; end
            vectors++;
            if (!wready) begin
                $display("FAIL w_timeout beat %0d: wready=%0b required 1", i, wready);
                miscompares++; wvalid = 1'b0; wlast = 1'b0; void'(bq.pop_back()); return;
            end
            if (legal) begin
                for (int b = 0; b < 8; b++) begin
                    if (strb[b]) model[(idx + i) % DEPTH][b*8 +: 8] = d[b*8 +: 8];
                end
            end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        vectors++;
        if (!bvalid) begin
            $display("FAIL b_timeout: bvalid=%0b required 1", bvalid);
            miscompares++; bready = 1'b0; void'(bq.pop_back()); return;
        end
        got = bq.pop_front();
        vectors++;
        if (bresp !== got.resp) begin
            $display("FAIL bresp: got %0h required %0h", bresp, got.resp);
            miscompares++;
        end
        vectors++;
        if (bid !== got.id) begin
            $display("FAIL bid: got %0h required %0h", bid, got.id);
            miscompares++;
        end
        tick();
        bready = 1'b0;
        exp_wr_cnt++;
        vectors++;
        if (bvalid !== 1'b0 || wr_cnt !== 16'(exp_wr_cnt)) begin
            $display("FAIL b_done: bvalid=%0b wr_cnt=%0d required 0 / %0d",
                     bvalid, wr_cnt, exp_wr_cnt);
            miscompares++;
        end
    endtask

    // toggle: rready alternates 1/0; abort_after>0: stop taking beats after that many,
    // leaving the burst open.
    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id,
                           input bit toggle, input int abort_after);
        r_exp_t e;
        int     n;
        int     beat;
        int     cyc;
        bit     stalled;
        logic [70:0] held;
        arvalid = 1'b1; araddr = addr; arlen = 8'(len); arsize = size;
        arburst = burst; arid = id;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        vectors++;
        if (!arready) begin
            $display("FAIL ar_timeout: arready=%0b required 1", arready);
            miscompares++; arvalid = 1'b0; rq.delete(); return;
        end
        tick();
        arvalid = 1'b0;
        beat = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (beat <= len) begin
            if (abort_after > 0 && beat == abort_after) begin
                rready = 1'b0;
                return;
            end
            rready = toggle ? (cyc % 2 == 0) : 1'b1;
            vectors++;
            if (rvalid !== 1'b1) begin
                $display("FAIL rvalid beat %0d: got %0b required 1", beat, rvalid);
                miscompares++; rready = 1'b0; rq.delete(); return;
            end
            if (stalled) begin
                vectors++;
                if ({rid, rresp, rlast, rdata} !== held) begin
                    $display("FAIL r_stall_hold beat %0d: got %h required %h",
                             beat, {rid, rresp, rlast, rdata}, held);
                    miscompares++;
                end
            end
            if (rready) begin
                e = rq.pop_front();
                vectors++;
                if (rdata !== e.data || rresp !== e.resp || rlast !== e.last || rid !== e.id)
                begin
                    $display("FAIL r_beat %0d: got data=%h resp=%0h last=%0b id=%0h required data=%h resp=%0h last=%0b id=%0h",
                             beat, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
                    miscompares++;
                end
                beat++;
                stalled = 1'b0;
            end else begin
                held    = {rid, rresp, rlast, rdata};
                stalled = 1'b1;
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        exp_rd_cnt++;
        vectors++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || rd_cnt !== 16'(exp_rd_cnt)) begin
            $display("FAIL r_done: rvalid=%0b arready=%0b rd_cnt=%0d required 0 / 1 / %0d",
                     rvalid, arready, rd_cnt, exp_rd_cnt);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        repeat (3) tick();
        vectors++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            $display("FAIL reset_handshakes: got %b required 000000",
                     {awready, wready, bvalid, arready, rvalid, rlast});
            miscompares++;
        end
        vectors++;
        if ({bresp, rresp, bid, rid} !== 12'h0 || rdata !== 64'h0) begin
            $display("FAIL reset_payload: got %h %h required 0 0", {bresp, rresp, bid, rid}, rdata);
            miscompares++;
        end
        vectors++;
        if (wr_cnt !== 16'h0 || rd_cnt !== 16'h0) begin
            $display("FAIL reset_counters: got %0d %0d required 0 0", wr_cnt, rd_cnt);
            miscompares++;
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (arready !== 1'b1 || awready !== 1'b1) begin
            $display("FAIL ready_after_reset: got ar=%0b aw=%0b required 1 1", arready, awready);
            miscompares++;
        end
    endtask

    task automatic test_burst16();
        do_write(32'h100, 15, 3'd3, 2'b01, 4'h5, 64'h0, 8'hFF, 0, 2'b00);
        push_model_read(32'h100, 15, 1'b1, 4'h9);
        do_read(32'h100, 15, 3'd3, 2'b01, 4'h9, 1'b0, 0);
    endtask

    task automatic test_strobes();
        do_write(32'h0, 0, 3'd3, 2'b01, 4'h1, 64'h1122334455667788, 8'hFF, 0, 2'b00);
        do_write(32'h0, 0, 3'd3, 2'b01, 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 2'b00);
        push_r(64'h11223344FFFFFFFF, 2'b00, 1'b1, 4'h3);
        do_read(32'h0, 0, 3'd3, 2'b01, 4'h3, 1'b0, 0);
    endtask

    task automatic test_wrap_backpressure();
        // Word 4094 = byte 0x7FF0; beats land at 4094, 4095, 0, 1.
        do_write(32'h7FF0, 3, 3'd3, 2'b01, 4'hA, 64'hA000_0000_0000_0000, 8'hFF, 0, 2'b00);
        push_model_read(32'h7FF0, 3, 1'b1, 4'hB);
        do_read(32'h7FF0, 3, 3'd3, 2'b01, 4'hB, 1'b1, 0);
        push_r(64'hA000_0000_0000_0002, 2'b00, 1'b0, 4'hC);
        push_r(64'hA000_0000_0000_0003, 2'b00, 1'b1, 4'hC);
        do_read(32'h0, 1, 3'd3, 2'b01, 4'hC, 1'b1, 0);
    endtask

    task automatic test_protocol_errors();
        do_write(32'h200, 0, 3'd3, 2'b01, 4'h4, 64'hCAFE_0000_0000_0001, 8'hFF, 0, 2'b00);
        do_write(32'h200, 0, 3'd3, 2'b00, 4'h6, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 2'b10);
        push_r(64'hCAFE_0000_0000_0001, 2'b00, 1'b1, 4'h7);
        do_read(32'h200, 0, 3'd3, 2'b01, 4'h7, 1'b0, 0);
        do_write(32'h300, 3, 3'd3, 2'b01, 4'h8, 64'h3000, 8'hFF, 1, 2'b10);
        push_model_read(32'h100, 1, 1'b0, 4'hD);
        do_read(32'h100, 1, 3'd2, 2'b01, 4'hD, 1'b0, 0);
    endtask

    task automatic test_concurrent();
        push_model_read(32'h100, 15, 1'b1, 4'h7);
        fork
            do_write(32'h400, 7, 3'd3, 2'b01, 4'h2, 64'h5555_0000_0000_0000, 8'hFF, 0, 2'b00);
            do_read(32'h100, 15, 3'd3, 2'b01, 4'h7, 1'b0, 0);
        join
        push_model_read(32'h400, 7, 1'b1, 4'h8);
        do_read(32'h400, 7, 3'd3, 2'b01, 4'h8, 1'b1, 0);
    endtask

    task automatic test_reset_midburst();
        push_model_read(32'h100, 15, 1'b1, 4'hE);
        do_read(32'h100, 15, 3'd3, 2'b01, 4'hE, 1'b0, 5);
        rq.delete();
        vectors++;
        if (rvalid !== 1'b1) begin
            $display("FAIL midburst_presenting: rvalid=%0b required 1", rvalid);
            miscompares++;
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (rvalid !== 1'b0 || wr_cnt !== 16'h0 || rd_cnt !== 16'h0) begin
            $display("FAIL midburst_reset: rvalid=%0b wr_cnt=%0d rd_cnt=%0d required 0 0 0",
                     rvalid, wr_cnt, rd_cnt);
            miscompares++;
        end
        rst = 1'b0;
        exp_wr_cnt = 0;
        exp_rd_cnt = 0;
        tick();
        vectors++;
        if (arready !== 1'b1) begin
            $display("FAIL arready_after_midburst_reset: got %0b required 1", arready);
            miscompares++;
        end
        push_model_read(32'h100, 3, 1'b1, 4'hF);
        do_read(32'h100, 3, 3'd3, 2'b01, 4'hF, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_burst16();
        test_strobes();
        test_wrap_backpressure();
        test_protocol_errors();
        test_concurrent();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
